bin_collector: RTL and testbench
================================

# bin_collector

Spectrum frame assembler feeding the note picker. It accepts per-bin DFT amplitudes as a valid/ready stream, in any order, and packs them into the 88 × 27-bit frame vector the note picker consumes. Bin 88 is A0 and bin 1 is C8. The block is double-buffered: it captures the next frame while the published frame is held stable until the consumer acknowledges it.

## Interface
- NBINS, 88, number of note bins
- AW, 27, amplitude width
- IW, 7, bin index width
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_bin  in  IW  bin index; 1..NBINS legal
- in_amp  in  AW  unsigned amplitude
- in_last  in  1  final sample of the current frame
- frame  out  NBINS*AW  published frame; bin k occupies [k*AW-1:(k-1)*AW]
- frame_valid  out  1  frame holds an unconsumed frame
- frame_ack  in  1  consumer takes the frame (transfer = frame_valid & frame_ack)
- frame_flags  out  3  {range_err, dup, missing} for the published frame
- frame_count  out  16  frames published, wraps modulo 2^16

## Operation
- Sample accept: in_valid & in_ready.
- Capture buffer: NBINS amplitude registers plus a written-mask bit per bin, plus sticky range/dup bits.
- On accept with 1 ≤ in_bin ≤ NBINS:
  - Write in_amp to slot in_bin; last write wins.
  - If the mask bit is already set, set dup.
  - Set the mask bit.
- On accept with in_bin = 0 or in_bin > NBINS: drop the sample and set range_err. in_last still takes effect.
- Swap:
  - frame ← capture (including the write accepted this cycle).
  - frame_flags ← {range_err, dup, ~&mask}.
  - frame_valid ← 1; frame_count += 1.
  - Clear the capture amplitudes, mask and sticky bits.
- Unwritten bins publish as 0.
- States:
  - INIT (reset state): in_ready = 0. Goes to COLLECT unconditionally on the next edge.
  - COLLECT: in_ready = 1. On accepted in_last: swap if (!frame_valid | frame_ack) and stay in COLLECT; otherwise apply the write and go to FULL.
  - FULL: in_ready = 0. On frame_ack: swap and go to COLLECT.
- frame_valid falls on a transfer only when no swap happens in the same cycle.
- A swap in the ack cycle keeps frame_valid high, and the new frame is visible the next cycle.
- frame, frame_flags and frame_count are stable whenever frame_valid = 1 and no transfer occurs.

## Timing
- All outputs are registered. in_ready is decoded from the registered state only; it has no combinational path from in_valid or frame_ack.
- Reset values: state INIT, in_ready 0, frame 0, frame_valid 0, frame_flags 0, frame_count 0, capture buffer cleared.
- in_ready rises on the first edge after rst_n deasserts.
- Latency: in_last accepted at edge N with the output free → new frame, frame_valid and frame_count visible after edge N.
- In FULL, frame_ack at edge M → swap at M, and in_ready = 1 after M.
- Throughput: one sample per cycle. No bubble between frames while the consumer keeps up.
- Reset mid-frame discards the capture buffer and any published frame, with no partial publish.
- frame_count wraps 0xFFFF → 0x0000.

## Structure
- vdft_pkg holds:
  - NBINS, AW, IW constants
  - the state enum {INIT, COLLECT, FULL}
  - frame_flags bit positions (MISSING=0, DUP=1, RANGE=2)
- Sub-module bin_slot, generated NBINS times: one capture register plus its written bit, with a write enable, clear and dup-detect output.
- The top level holds the FSM, the sticky range bit, the output registers and the counter.

## Test plan
- Bins 88..1, amp = bin*1000, in_last on bin 1, frame_ack held 1 → frame_valid one cycle after the last accept; slot k = k*1000; flags 000; frame_count 1.
- frame_ack = 0, send two full frames → after the second in_last, in_ready = 0 and the first frame is unchanged. Pulse frame_ack → the second frame is published the next cycle, in_ready = 1 and frame_count = 2.
- Bin 5 amp 7, bin 5 amp 9, in_last on that second sample → slot 5 = 9, all other slots 0, flags = 011.
- Full frame plus bin 0 and bin 89 samples → those samples change no slot; flags = 100.
- Reset after 40 accepted bins → frame_valid 0, frame 0, frame_count 0, in_ready 0 then 1. The next full frame publishes with flags 000.
- in_last accepted in the same cycle as frame_ack on an old frame → swap with no FULL state; frame_valid stays high and the new frame is visible the next cycle.

Source files
------------

// File: rtl/vdft_pkg.sv
// Shared constants and types for the spectrum frame assembler.
package vdft_pkg;

    localparam int unsigned NBINS = 88;
    localparam int unsigned AW    = 27;
    localparam int unsigned IW    = 7;

    typedef enum logic [1:0] {INIT, COLLECT, FULL} state_e;

    // Bit positions within frame_flags
    localparam int unsigned MISSING = 0;
    localparam int unsigned DUP     = 1;
    localparam int unsigned RANGE   = 2;

endpackage

// File: rtl/bin_slot.sv
// One capture slot: amplitude register plus written bit, with duplicate-write detect.
module bin_slot
    import vdft_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] wdata,
    output logic [AW-1:0] amp,
    output logic          written,
    output logic          dup
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            amp     <= '0;
            written <= 1'b0;
        end else if (clr) begin
            amp     <= '0;
            written <= 1'b0;
        end else if (we) begin
            amp     <= wdata;
            written <= 1'b1;
        end
    end

    assign dup = we & written;

endmodule

// File: rtl/bin_collector.sv
// Double-buffered frame assembler: captures per-bin amplitudes, publishes whole frames.
module bin_collector
    import vdft_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IW-1:0]       in_bin,
    input  logic [AW-1:0]       in_amp,
    input  logic                in_last,
    output logic [NBINS*AW-1:0] frame,
    output logic                frame_valid,
    input  logic                frame_ack,
    output logic [2:0]          frame_flags,
    output logic [15:0]         frame_count
);

    state_e state_q, state_d;
    logic   swap;
    logic   accept;
    logic   in_range;
    logic   range_q, dup_q;
    logic   range_now, dup_now;
    logic [2:0] flags_now;

    logic [NBINS-1:0]    we;
    logic [NBINS-1:0]    written;
    logic [NBINS-1:0]    dup_hit;
    logic [AW-1:0]       slot_amp [NBINS];
    logic [NBINS*AW-1:0] cap_view;

    assign in_ready = (state_q == COLLECT);
    assign accept   = in_valid & in_ready;
    assign in_range = (in_bin != '0) && (in_bin <= IW'(NBINS));

    for (genvar g = 0; g < NBINS; g++) begin : g_slot
        assign we[g] = accept & in_range & (in_bin == IW'(g + 1));

        bin_slot u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (swap),
            .we      (we[g]),
            .wdata   (in_amp),
            .amp     (slot_amp[g]),
            .written (written[g]),
            .dup     (dup_hit[g])
        );

        // Fold in this cycle's write so the swap publishes it
        assign cap_view[g*AW +: AW] = we[g] ? in_amp : slot_amp[g];
    end

    assign range_now = range_q | (accept & ~in_range);
    assign dup_now   = dup_q | (|dup_hit);

    always_comb begin
        flags_now          = '0;
        flags_now[RANGE]   = range_now;
        flags_now[DUP]     = dup_now;
        flags_now[MISSING] = ~&(written | we);
    end

    always_comb begin
        state_d = state_q;
        swap    = 1'b0;
        unique case (state_q)
            INIT: state_d = COLLECT;
            COLLECT: begin
                if (accept && in_last) begin
                    if (!frame_valid || frame_ack) swap = 1'b1;
                    else                           state_d = FULL;
                end
            end
            FULL: begin
                if (frame_ack) begin
                    swap    = 1'b1;
                    state_d = COLLECT;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            range_q <= 1'b0;
            dup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            range_q <= swap ? 1'b0 : range_now;
            dup_q   <= swap ? 1'b0 : dup_now;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame       <= '0;
            frame_valid <= 1'b0;
            frame_flags <= '0;
            frame_count <= '0;
        end else if (swap) begin
            frame       <= cap_view;
            frame_valid <= 1'b1;
            frame_flags <= flags_now;
            frame_count <= frame_count + 16'd1;
        end else if (frame_valid && frame_ack) begin
            frame_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bin_collector.sv
// Directed self-checking bench for bin_collector.
module tb_bin_collector;
    import vdft_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [IW-1:0]       in_bin = '0;
    logic [AW-1:0]       in_amp = '0;
    logic                in_last = 1'b0;
    logic [NBINS*AW-1:0] frame;
    logic                frame_valid;
    logic                frame_ack = 1'b0;
    logic [2:0]          frame_flags;
    logic [15:0]         frame_count;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] exp_amp [1:NBINS];

    always #5 clk = ~clk;

    bin_collector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_bin      (in_bin),
        .in_amp      (in_amp),
        .in_last     (in_last),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .frame_flags (frame_flags),
        .frame_count (frame_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_frame(input string tag);
        for (int k = 1; k <= NBINS; k++)
            check($sformatf("%s slot%0d", tag, k), 32'(frame[(k-1)*AW +: AW]), 32'(exp_amp[k]));
    endtask

    task automatic set_exp(input int mult, input int add);
        for (int k = 1; k <= NBINS; k++) exp_amp[k] = AW'(k * mult + add);
    endtask

    // Drive one sample at a negedge, return at the negedge after it is clocked in
    task automatic send(input int bin, input int amp, input bit last);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_bin   = IW'(bin);
        in_amp   = AW'(amp);
        in_last  = last;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        #1;
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_count", 32'(frame_count), 32'd0);
        check("rst_flags", 32'(frame_flags), 32'd0);
        set_exp(0, 0);
        check_frame("rst_frame");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("init_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("init_ready_high", 32'(in_ready), 32'd1);

        // Full frame descending, consumer always ready
        frame_ack = 1'b1;
        for (int b = NBINS; b >= 1; b--) send(b, b * 1000, b == 1);
        check("t1_valid", 32'(frame_valid), 32'd1);
        check("t1_flags", 32'(frame_flags), 32'd0);
        check("t1_count", 32'(frame_count), 32'd1);
        set_exp(1000, 0);
        check_frame("t1");
        idle();
        tick(1);
        check("t1_consumed", 32'(frame_valid), 32'd0);
        frame_ack = 1'b0;

        // Two frames with the consumer stalled
        for (int b = 1; b <= NBINS; b++) send(b, b + 5, b == NBINS);
        check("t2a_count", 32'(frame_count), 32'd2);
        for (int b = 1; b <= NBINS; b++) send(b, b * 3, b == NBINS);
        idle();
        check("t2_full_ready", 32'(in_ready), 32'd0);
        check("t2_full_count", 32'(frame_count), 32'd2);
        tick(3);
        check("t2_held_ready", 32'(in_ready), 32'd0);
        set_exp(1, 5);
        check_frame("t2_held");
        frame_ack = 1'b1;
        tick(1);
        check("t2_swap_valid", 32'(frame_valid), 32'd1);
        check("t2_swap_ready", 32'(in_ready), 32'd1);
        check("t2_swap_count", 32'(frame_count), 32'd3);
        check("t2_swap_flags", 32'(frame_flags), 32'd0);
        set_exp(3, 0);
        check_frame("t2_b");
        tick(1);
        check("t2_drained", 32'(frame_valid), 32'd0);
        frame_ack = 1'b0;

        // Duplicate write, last write wins
        send(5, 7, 1'b0);
        send(5, 9, 1'b1);
        idle();
        check("t3_flags", 32'(frame_flags), 32'b011);
        check("t3_count", 32'(frame_count), 32'd4);
        set_exp(0, 0);
        exp_amp[5] = 9;
        check_frame("t3");
        frame_ack = 1'b1;
        tick(1);
        frame_ack = 1'b0;

        // Out-of-range bins are dropped but flagged
        for (int b = 1; b <= NBINS; b++) begin
            if (b == 30) send(0, 123, 1'b0);
            if (b == 60) send(89, 456, 1'b0);
            if (b == 70) send(127, 789, 1'b0);
            send(b, b, b == NBINS);
        end
        idle();
        check("t4_flags", 32'(frame_flags), 32'b100);
        check("t4_count", 32'(frame_count), 32'd5);
        set_exp(1, 0);
        check_frame("t4");

        // Reset mid-frame with a published frame outstanding
        for (int b = 1; b <= 40; b++) send(b, b * 2, 1'b0);
        idle();
        rst_n = 1'b0;
        #1;
        check("t5_valid", 32'(frame_valid), 32'd0);
        check("t5_count", 32'(frame_count), 32'd0);
        check("t5_flags", 32'(frame_flags), 32'd0);
        check("t5_ready", 32'(in_ready), 32'd0);
        set_exp(0, 0);
        check_frame("t5_rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t5_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("t5_ready_high", 32'(in_ready), 32'd1);
        for (int b = 1; b <= NBINS; b++) send(b, b * 7, b == NBINS);
        idle();
        check("t5_new_flags", 32'(frame_flags), 32'd0);
        check("t5_new_count", 32'(frame_count), 32'd1);
        set_exp(7, 0);
        check_frame("t5_new");

        // in_last in the same cycle as the ack of the old frame
        for (int b = NBINS; b >= 2; b--) send(b, b * 11, 1'b0);
        check("t6_pre_valid", 32'(frame_valid), 32'd1);
        frame_ack = 1'b1;
        send(1, 11, 1'b1);
        idle();
        check("t6_valid", 32'(frame_valid), 32'd1);
        check("t6_ready", 32'(in_ready), 32'd1);
        check("t6_count", 32'(frame_count), 32'd2);
        check("t6_flags", 32'(frame_flags), 32'd0);
        set_exp(11, 0);
        check_frame("t6");
        tick(1);
        check("t6_drained", 32'(frame_valid), 32'd0);
        frame_ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
